peripheral_syn_reader: RTL and testbench
========================================

// Module: peripheral_syn_reader
// PURPOSE
//  Read side of the commit sync-register interface. On each commit strobe it requests a syn_reg1 update,
//  then snapshots syn_reg1 {instrcnt,pc} and syn_reg2 {64'b0,rfData} into a record FIFO.
//  Records drain as a 32-bit valid/ready beat stream to the host/checker link; tlast marks the final beat.
//  Sits between the sync-register peripheral and the debug/DMA streaming port.
// PARAMETERS
//  DEPTH     4    record FIFO entries (power of 2, >=2)
//  DROP_W    16   drop-counter width
// PORTS
//  clk              in   1       clock
//  resetn           in   1       async active-low reset
//  sync_valid       in   1       commit strobe (same signal that latches syn_reg2)
//  syn_reg1         in   128     {instrcnt[127:64], pc[63:0]}
//  syn_reg2         in   128     {64'b0, rfData[63:0]}
//  syn_reg1_update  out  1       one-cycle request to latch syn_reg1
//  m_tdata          out  32      stream data
//  m_tvalid         out  1       stream valid
//  m_tready         in   1       stream ready
//  m_tlast          out  1       last beat of record
//  drop_cnt         out  DROP_W  saturating count of lost commits
//  fifo_level       out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: syn_reg1_update=0, m_tvalid=0, m_tlast=0, m_tdata=0, drop_cnt=0, fifo_level=0, FSM=IDLE, beat=0.
//  Capture FSM (one state per cycle): IDLE -sync_valid-> UPD (syn_reg1_update=1) -> LOAD -> IDLE.
//   LOAD samples syn_reg1/syn_reg2 (both settled by then) and pushes record {rfData,instrcnt,pc} (192b).
//  sync_valid seen in UPD or LOAD: commit lost, drop_cnt+1, FSM unaffected.
//  LOAD with FIFO full (no same-cycle pop): record discarded, drop_cnt+1. Same-cycle pop frees space: push.
//  drop_cnt saturates at all-ones; never wraps.
//  Serializer: head record, 6 beats: pc[31:0], pc[63:32], instrcnt[31:0], instrcnt[63:32],
//   rfData[31:0], rfData[63:32]; m_tlast=1 on beat 5 only. Beat advances on m_tvalid&&m_tready;
//   pop after last beat accepted. m_tvalid/m_tdata/m_tlast stable while m_tvalid&&!m_tready.
//  m_tvalid=1 whenever FIFO non-empty; back-to-back records without bubble.
//  Latency: sync_valid at cycle 0 -> record in FIFO after cycle 2 edge -> m_tvalid=1 at cycle 3 if empty.
//  FIFO pointers wrap modulo DEPTH; fifo_level counts 0..DEPTH.
//  resetn low mid-record: immediate clear, partial record discarded, no tlast emitted.
// CONFIGURATION
//  SYN_RD_SEQ_EN defined: header beat precedes each record: {seq[15:0], drop_cnt[15:0] (sat. to 16b)};
//   seq = 16-bit record counter, +1 per pushed record, wraps 0xFFFF->0; record = 7 beats, tlast on beat 6.
//  Undefined: no header, no seq counter, 6 beats/record.
// STRUCTURE
//  Package syn_rd_pkg: syn_rec_t {rfdata,instrcnt,pc}, REC_BEATS (6/7 per macro), BEAT_W=32, FSM state enum.
//  Sub-module syn_rec_fifo: synchronous FIFO of syn_rec_t, DEPTH param, push/pop/full/empty/level.
//  Top: capture FSM, drop counter, beat counter/mux, optional seq counter.
// TESTING
//  1 single commit pc=0x8000_0000, instrcnt=1, rfData=0xDEAD_BEEF_0123_4567, tready=1 ->
//    beats 0x80000000,0,1,0,0x01234567,0xDEADBEEF; tlast on 6th; syn_reg1_update one pulse.
//  2 sync_valid on 2 consecutive cycles -> one record, drop_cnt=1.
//  3 tready=0, 5 spaced commits, DEPTH=4 -> fifo_level=4, drop_cnt=1; release -> 24 beats in order.
//  4 tready toggling 1/0 every cycle -> data/tlast held on stalls, no beat duplicated or skipped.
//  5 resetn low on beat 3 of record -> all outputs to reset values asynchronously; next commit restarts at beat 0.
//  6 SYN_RD_SEQ_EN: 3 commits -> headers 0x0000_0000, 0x0001_0000, 0x0002_0000; 7 beats each.

Source files
------------

// File: rtl/syn_rd_pkg.sv
// Shared types for the commit sync-register reader: record layout, beat count, capture states.
// SYN_RD_SEQ_EN adds a {seq, drop} header beat to every record.
package syn_rd_pkg;

   localparam int BEAT_W = 32;

`ifdef SYN_RD_SEQ_EN
   localparam int REC_BEATS = 7;
   typedef struct packed {
      logic [15:0] seq;
      logic [15:0] drop;
      logic [63:0] rfdata;
      logic [63:0] instrcnt;
      logic [63:0] pc;
   } syn_rec_t;
`else
   localparam int REC_BEATS = 6;
   typedef struct packed {
      logic [63:0] rfdata;
      logic [63:0] instrcnt;
      logic [63:0] pc;
   } syn_rec_t;
`endif

   localparam logic [2:0] LAST_BEAT = 3'(REC_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UPD  = 2'd1,
      ST_LOAD = 2'd2
   } syn_state_e;

   // Payload word k of a record, low half of each 64-bit field first.
   function automatic logic [BEAT_W-1:0] rec_word(input syn_rec_t rec, input logic [2:0] k);
      logic [BEAT_W-1:0] w;
      case (k)
         3'd0:    w = rec.pc[31:0];
         3'd1:    w = rec.pc[63:32];
         3'd2:    w = rec.instrcnt[31:0];
         3'd3:    w = rec.instrcnt[63:32];
         3'd4:    w = rec.rfdata[31:0];
         3'd5:    w = rec.rfdata[63:32];
         default: w = {BEAT_W{1'b0}};
      endcase
      return w;
   endfunction

   function automatic logic [BEAT_W-1:0] beat_word(input syn_rec_t rec, input logic [2:0] beat);
      logic [BEAT_W-1:0] w;
`ifdef SYN_RD_SEQ_EN
      if (beat == 3'd0) begin
         w = {rec.seq, rec.drop};
      end else begin
         w = rec_word(rec, beat - 3'd1);
      end
`else
      w = rec_word(rec, beat);
`endif
      return w;
   endfunction

endpackage

// File: rtl/peripheral_syn_reader_if.sv
// Valid/ready beat stream from the sync-register reader to the host/checker link.
interface peripheral_syn_reader_if;
   import syn_rd_pkg::*;

   logic [BEAT_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
   modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/syn_rec_fifo.sv
// Synchronous record FIFO; the caller never pushes when full without a same-cycle pop.
module syn_rec_fifo
   import syn_rd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  syn_rec_t               din,
   output syn_rec_t               dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   syn_rec_t        mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;

   // Record storage; contents are don't-care until counted in.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == {(AW+1){1'b0}});
   assign level = count_r;

endmodule

// File: rtl/peripheral_syn_reader.sv
// Commit sync-register reader: captures {rfData,instrcnt,pc} per commit and streams it as 32-bit beats.
// Optional SYN_RD_SEQ_EN prepends a {seq, drop_cnt} header beat to each record.
module peripheral_syn_reader
   import syn_rd_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      sync_valid,
   input  logic [127:0]              syn_reg1,
   input  logic [127:0]              syn_reg2,
   output logic                      syn_reg1_update,
   peripheral_syn_reader_if.master   strm,
   output logic [DROP_W-1:0]         drop_cnt,
   output logic [$clog2(DEPTH):0]    fifo_level
);
   syn_state_e        state_r;
   logic              upd_r;
   logic [DROP_W-1:0] drop_cnt_r;
   logic [2:0]        beat_r;
   syn_rec_t          rec_in_s;
   syn_rec_t          head_s;
   logic              full_s, empty_s, tvalid_s, last_s, pop_s, push_s;
   logic              lost_commit_s, lost_rec_s;
   logic [1:0]        drop_inc_s;
   logic              syn_reg2_unused_s;

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input logic [1:0] inc);
      logic [DROP_W+1:0] sum;
      sum = (DROP_W+2)'(a) + (DROP_W+2)'(inc);
      if (sum > (DROP_W+2)'({DROP_W{1'b1}})) begin
         return {DROP_W{1'b1}};
      end else begin
         return sum[DROP_W-1:0];
      end
   endfunction

`ifdef SYN_RD_SEQ_EN
   logic [15:0] seq_r;

   function automatic logic [15:0] sat16(input logic [DROP_W-1:0] v);
      logic [DROP_W+16:0] ext;
      ext = (DROP_W+17)'(v);
      if (ext > (DROP_W+17)'(17'h0FFFF)) begin
         return 16'hFFFF;
      end else begin
         return ext[15:0];
      end
   endfunction

   // Sequence number of the next record to be pushed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seq_r <= 16'h0000;
      end else if (push_s) begin
         seq_r <= seq_r + 16'h0001;
      end else begin
         seq_r <= seq_r;
      end
   end
`endif

   // Push/pop/drop decisions; a pop on the final beat frees space for a same-cycle push.
   always_comb begin
      tvalid_s      = !empty_s;
      last_s        = (beat_r == LAST_BEAT);
      pop_s         = tvalid_s && strm.m_tready && last_s;
      push_s        = (state_r == ST_LOAD) && (!full_s || pop_s);
      lost_commit_s = sync_valid && (state_r != ST_IDLE);
      lost_rec_s    = (state_r == ST_LOAD) && full_s && !pop_s;
      drop_inc_s    = {1'b0, lost_commit_s} + {1'b0, lost_rec_s};
      rec_in_s          = '0;
      rec_in_s.pc       = syn_reg1[63:0];
      rec_in_s.instrcnt = syn_reg1[127:64];
      rec_in_s.rfdata   = syn_reg2[63:0];
`ifdef SYN_RD_SEQ_EN
      rec_in_s.seq      = seq_r;
      rec_in_s.drop     = sat16(drop_cnt_r);
`endif
   end

   // Capture FSM: request a syn_reg1 update, then sample both registers one cycle later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         upd_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= sync_valid ? ST_UPD : ST_IDLE;
               upd_r   <= sync_valid;
            end
            ST_UPD: begin
               state_r <= ST_LOAD;
               upd_r   <= 1'b0;
            end
            ST_LOAD: begin
               state_r <= ST_IDLE;
               upd_r   <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               upd_r   <= 1'b0;
            end
         endcase
      end
   end

   // Lost commits and discarded records; saturates rather than wrapping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt_r <= {DROP_W{1'b0}};
      end else begin
         drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
      end
   end

   // Beat index within the head record; advances only on an accepted beat.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_r <= 3'd0;
      end else if (tvalid_s && strm.m_tready) begin
         beat_r <= last_s ? 3'd0 : beat_r + 3'd1;
      end else begin
         beat_r <= beat_r;
      end
   end

   syn_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_s),
      .pop    (pop_s),
      .din    (rec_in_s),
      .dout   (head_s),
      .full   (full_s),
      .empty  (empty_s),
      .level  (fifo_level)
   );

   assign syn_reg2_unused_s = ^syn_reg2[127:64];
   assign syn_reg1_update   = upd_r;
   assign drop_cnt          = drop_cnt_r;
   assign strm.m_tvalid     = tvalid_s;
   assign strm.m_tlast      = tvalid_s && last_s;
   assign strm.m_tdata      = tvalid_s ? beat_word(head_s, beat_r) : {BEAT_W{1'b0}};

endmodule

// File: tb/tb_peripheral_syn_reader.sv
// Directed self-checking bench for peripheral_syn_reader (DEPTH=4, DROP_W=16).
module tb_peripheral_syn_reader;
`ifdef SYN_RD_SEQ_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int REC = 6 + HDR;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         sync_valid = 1'b0;
   logic [127:0] syn_reg1 = 128'h0;
   logic [127:0] syn_reg2 = 128'h0;
   logic         syn_reg1_update;
   logic [15:0]  drop_cnt;
   logic [2:0]   fifo_level;

   peripheral_syn_reader_if strm ();

   peripheral_syn_reader #(.DEPTH(4), .DROP_W(16)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .sync_valid      (sync_valid),
      .syn_reg1        (syn_reg1),
      .syn_reg2        (syn_reg2),
      .syn_reg1_update (syn_reg1_update),
      .strm            (strm),
      .drop_cnt        (drop_cnt),
      .fifo_level      (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int upd_pulses = 0;
   logic [31:0] got_q [$];
   logic        got_last_q [$];

   logic [63:0] rec_pc [5] = '{64'h0000_0000_8000_0000, 64'h1111_2222_3333_4444, 64'h0000_0000_8000_0004,
                               64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_1000};
   logic [63:0] rec_ic [5] = '{64'h1, 64'h2, 64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 64'h5};
   logic [63:0] rec_rf [5] = '{64'hDEAD_BEEF_0123_4567, 64'hCAFE_F00D_0BAD_BEEF, 64'h0123_4567_89AB_CDEF,
                               64'h0, 64'h5555_AAAA_5555_AAAA};

   always @(negedge clk) if (syn_reg1_update === 1'b1) upd_pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic [31:0] exp_word(input int r, input logic [31:0] hdr, input int idx);
      logic [31:0] w [0:6];
      w[0] = hdr;
      w[1] = rec_pc[r][31:0];  w[2] = rec_pc[r][63:32];
      w[3] = rec_ic[r][31:0];  w[4] = rec_ic[r][63:32];
      w[5] = rec_rf[r][31:0];  w[6] = rec_rf[r][63:32];
      return w[idx + 1 - HDR];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      strm.m_tready = 1'b0;
      sync_valid = 1'b0;
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic set_rec(input int i);
      syn_reg1 = {rec_ic[i], rec_pc[i]};
      syn_reg2 = {64'hFFFF_0000_FFFF_0000, rec_rf[i]};
   endtask

   task automatic commit(input int i);
      set_rec(i);
      sync_valid = 1'b1;
      tick();
      sync_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic collect(input int n, input int budget);
      int cyc;
      cyc = 0;
      got_q.delete();
      got_last_q.delete();
      while (got_q.size() < n && cyc < budget) begin
         if (strm.m_tvalid === 1'b1 && strm.m_tready === 1'b1) begin
            got_q.push_back(strm.m_tdata);
            got_last_q.push_back(strm.m_tlast);
         end
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      sync_valid = 1'b0;
      strm.m_tready = 1'b0;
      resetn = 1'b0;
      #1;
      checks += 6;
      if (syn_reg1_update !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b expected 0", syn_reg1_update); end
      if (strm.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", strm.m_tvalid); end
      if (strm.m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", strm.m_tlast); end
      if (strm.m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", strm.m_tdata); end
      if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int base;
      do_reset();
      strm.m_tready = 1'b1;
      base = upd_pulses;
      set_rec(0);
      sync_valid = 1'b1;
      tick();
      sync_valid = 1'b0;
      checks++;
      if (syn_reg1_update !== 1'b1) begin errors++; $display("FAIL single_upd: got %b expected 1", syn_reg1_update); end
      tick();
      checks++;
      if (strm.m_tvalid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", strm.m_tvalid); end
      tick();
      checks += 2;
      if (strm.m_tvalid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", strm.m_tvalid); end
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
      collect(REC, 30);
      checks++;
      if (got_q.size() != REC) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), REC); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] !== exp_word(0, 32'h0, i)) begin
            errors++; $display("FAIL single_beat%0d: got %h expected %h", i, got_q[i], exp_word(0, 32'h0, i));
         end
         if (got_last_q[i] !== (i == REC - 1)) begin
            errors++; $display("FAIL single_last%0d: got %b expected %b", i, got_last_q[i], (i == REC - 1));
         end
      end
      checks += 2;
      if (upd_pulses - base != 1) begin errors++; $display("FAIL single_upd_pulses: got %0d expected 1", upd_pulses - base); end
      if (strm.m_tvalid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", strm.m_tvalid); end
   endtask

   task automatic test_double_strobe();
      do_reset();
      set_rec(1);
      sync_valid = 1'b1;
      tick();
      tick();
      sync_valid = 1'b0;
      tick();
      tick();
      checks += 2;
      if (drop_cnt !== 16'd1) begin errors++; $display("FAIL double_drop: got %0d expected 1", drop_cnt); end
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL double_level: got %0d expected 1", fifo_level); end
      strm.m_tready = 1'b1;
      collect(REC, 30);
      checks++;
      if (got_q.size() != REC) begin errors++; $display("FAIL double_count: got %0d expected %0d", got_q.size(), REC); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_word(1, 32'h0000_0001, i)) begin
            errors++; $display("FAIL double_beat%0d: got %h expected %h", i, got_q[i], exp_word(1, 32'h0000_0001, i));
         end
      end
      tick();
      checks++;
      if (strm.m_tvalid !== 1'b0) begin errors++; $display("FAIL double_extra_record: got %b expected 0", strm.m_tvalid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) commit(i);
      checks += 3;
      if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
      if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_cnt); end
      if (strm.m_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", strm.m_tvalid); end
      strm.m_tready = 1'b1;
      collect(4 * REC, 100);
      checks++;
      if (got_q.size() != 4 * REC) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), 4 * REC); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] !== exp_word(i / REC, {16'(i / REC), 16'h0}, i % REC)) begin
            errors++; $display("FAIL ovf_beat%0d: got %h expected %h", i, got_q[i], exp_word(i / REC, {16'(i / REC), 16'h0}, i % REC));
         end
         if (got_last_q[i] !== (i % REC == REC - 1)) begin
            errors++; $display("FAIL ovf_last%0d: got %b expected %b", i, got_last_q[i], (i % REC == REC - 1));
         end
      end
      checks += 2;
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_level_end: got %0d expected 0", fifo_level); end
      if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_end: got %0d expected 1", drop_cnt); end
   endtask

   task automatic test_toggle();
      int cyc;
      bit stall;
      logic [31:0] held_d;
      logic held_l;
      do_reset();
      commit(2);
      commit(3);
      got_q.delete();
      got_last_q.delete();
      cyc = 0;
      stall = 1'b0;
      held_d = 32'h0;
      held_l = 1'b0;
      while (got_q.size() < 2 * REC && cyc < 100) begin
         strm.m_tready = (cyc % 2 == 0);
         if (strm.m_tvalid === 1'b1) begin
            if (stall) begin
               checks += 2;
               if (strm.m_tdata !== held_d) begin errors++; $display("FAIL toggle_hold_data: got %h expected %h", strm.m_tdata, held_d); end
               if (strm.m_tlast !== held_l) begin errors++; $display("FAIL toggle_hold_last: got %b expected %b", strm.m_tlast, held_l); end
            end
            if (strm.m_tready) begin
               got_q.push_back(strm.m_tdata);
               got_last_q.push_back(strm.m_tlast);
               stall = 1'b0;
            end else begin
               stall = 1'b1;
               held_d = strm.m_tdata;
               held_l = strm.m_tlast;
            end
         end
         tick();
         cyc++;
      end
      checks++;
      if (got_q.size() != 2 * REC) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), 2 * REC); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] !== exp_word(2 + i / REC, {16'(i / REC), 16'h0}, i % REC)) begin
            errors++; $display("FAIL toggle_beat%0d: got %h expected %h", i, got_q[i], exp_word(2 + i / REC, {16'(i / REC), 16'h0}, i % REC));
         end
         if (got_last_q[i] !== (i % REC == REC - 1)) begin
            errors++; $display("FAIL toggle_last%0d: got %b expected %b", i, got_last_q[i], (i % REC == REC - 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      strm.m_tready = 1'b1;
      commit(4);
      collect(3, 30);
      checks++;
      if (strm.m_tdata !== exp_word(4, 32'h0, 3)) begin
         errors++; $display("FAIL mid_beat3: got %h expected %h", strm.m_tdata, exp_word(4, 32'h0, 3));
      end
      #2;
      resetn = 1'b0;
      #1;
      checks += 5;
      if (strm.m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b expected 0", strm.m_tvalid); end
      if (strm.m_tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_tlast: got %b expected 0", strm.m_tlast); end
      if (strm.m_tdata !== 32'h0) begin errors++; $display("FAIL mid_rst_tdata: got %h expected 0", strm.m_tdata); end
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d expected 0", fifo_level); end
      if (syn_reg1_update !== 1'b0) begin errors++; $display("FAIL mid_rst_upd: got %b expected 0", syn_reg1_update); end
      tick();
      resetn = 1'b1;
      tick();
      commit(1);
      collect(REC, 30);
      checks++;
      if (got_q.size() != REC) begin errors++; $display("FAIL mid_restart_count: got %0d expected %0d", got_q.size(), REC); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_word(1, 32'h0, i)) begin
            errors++; $display("FAIL mid_restart_beat%0d: got %h expected %h", i, got_q[i], exp_word(1, 32'h0, i));
         end
      end
   endtask

`ifdef SYN_RD_SEQ_EN
   task automatic test_seq();
      logic [31:0] hdr_exp [3];
      hdr_exp = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000};
      do_reset();
      for (int i = 0; i < 3; i++) commit(i);
      strm.m_tready = 1'b1;
      collect(21, 60);
      checks++;
      if (got_q.size() != 21) begin errors++; $display("FAIL seq_count: got %0d expected 21", got_q.size()); end
      for (int r = 0; r < 3 && got_q.size() == 21; r++) begin
         checks += 2;
         if (got_q[r * 7] !== hdr_exp[r]) begin errors++; $display("FAIL seq_hdr%0d: got %h expected %h", r, got_q[r * 7], hdr_exp[r]); end
         if (got_last_q[r * 7 + 6] !== 1'b1) begin errors++; $display("FAIL seq_last%0d: got %b expected 1", r, got_last_q[r * 7 + 6]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_double_strobe();
      test_overflow();
      test_toggle();
      test_reset_mid();
`ifdef SYN_RD_SEQ_EN
      test_seq();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
